// File: rtl/if_stage.sv
// RV64 instruction fetch: owns PC_F, one outstanding imem request, drives the IF/ID register.
// Latency: IF/ID loads on the edge that rvalid arrives; decode stalls park one response in a 1-entry buffer.
module if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect,
    input  logic [63:0] redirect_PC,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_D,
    output logic [63:0] PC_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc_f;
    logic [63:0] r_pc_inflight;
    logic        r_buf_vld;
    logic [31:0] r_buf_instr;
    logic [63:0] r_buf_pc;
    logic [31:0] r_instr_d;
    logic [63:0] r_pc_d;
    logic        r_valid_d;

    logic        w_accept;
    logic        w_resp;
    logic [63:0] w_redirect_tgt;

    // A full buffer blocks new fetches, so WAIT never coexists with a full buffer.
    assign imem_req       = reset && (r_state == S_FETCH) && !r_buf_vld && !redirect;
    assign imem_addr      = r_pc_f;
    assign w_accept       = imem_req && imem_ready;
    assign w_resp         = (r_state == S_WAIT) && imem_rvalid;
    assign w_redirect_tgt = redirect_PC & ~64'h3;

    assign instruction_D  = r_instr_d;
    assign PC_D           = r_pc_d;
    assign valid_D        = r_valid_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_pc_f        <= RESET_PC;
            r_pc_inflight <= RESET_PC;
            r_buf_vld     <= 1'b0;
            r_buf_instr   <= NOP_INSTR;
            r_buf_pc      <= 64'h0;
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= 64'h0;
            r_valid_d     <= 1'b0;
        end else if (redirect) begin
            r_pc_f    <= w_redirect_tgt;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
            r_buf_vld <= 1'b0;
            // An in-flight response must be swallowed before the new target is fetched.
            case (r_state)
                S_FETCH: r_state <= S_FETCH;
                default: r_state <= imem_rvalid ? S_FETCH : S_DROP;
            endcase
        end else begin
            if (w_accept) begin
                r_pc_inflight <= r_pc_f;
                r_pc_f        <= r_pc_f + 64'd4;
                r_state       <= S_WAIT;
            end
            if ((r_state == S_WAIT || r_state == S_DROP) && imem_rvalid) begin
                r_state <= S_FETCH;
            end
            if (!stall_D) begin
                if (r_buf_vld) begin
                    r_instr_d <= r_buf_instr;
                    r_pc_d    <= r_buf_pc;
                    r_valid_d <= 1'b1;
                    r_buf_vld <= 1'b0;
                end else if (w_resp) begin
                    r_instr_d <= imem_rdata;
                    r_pc_d    <= r_pc_inflight;
                    r_valid_d <= 1'b1;
                end else begin
                    r_instr_d <= NOP_INSTR;
                    r_valid_d <= 1'b0;
                end
            end
            if (w_resp && (stall_D || r_buf_vld)) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_pc_inflight;
                r_buf_vld   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, then randomized traffic against a queue-level model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        stall_D;
    logic        redirect;
    logic [63:0] redirect_PC;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_D;
    logic [63:0] PC_D;
    logic        valid_D;

    if_stage dut (
        .clk(clk), .reset(reset), .stall_D(stall_D), .redirect(redirect),
        .redirect_PC(redirect_PC), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction_D(instruction_D), .PC_D(PC_D), .valid_D(valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic [31:0] e_instr;
        logic [63:0] e_pcd;
        logic        e_vld;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst_n, input logic stall, input logic redir,
                                input logic [63:0] rpc, input logic rdy, input logic rv,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [63:0] e_addr, input logic [31:0] e_instr,
                                input logic [63:0] e_pcd, input logic e_vld);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.e_req = e_req;
        v.e_addr = e_addr; v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_vld = e_vld;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle: combinational outputs checked before the edge, IF/ID after it.
    task automatic apply(input vec_t t, input string nm);
        reset       = t.rst_n;
        stall_D     = t.stall;
        redirect    = t.redir;
        redirect_PC = t.rpc;
        imem_ready  = t.rdy;
        imem_rvalid = t.rv;
        imem_rdata  = t.rdata;
        #1;
        chk({nm, " req"}, {63'h0, imem_req}, {63'h0, t.e_req});
        chk({nm, " addr"}, imem_addr, t.e_addr);
        @(posedge clk);
        #1;
        chk({nm, " instr"}, {32'h0, instruction_D}, {32'h0, t.e_instr});
        chk({nm, " pc_d"}, PC_D, t.e_pcd);
        chk({nm, " valid"}, {63'h0, valid_D}, {63'h0, t.e_vld});
    endtask

    // Randomized-phase model state
    ent_t        q[$];
    ent_t        e;
    logic [63:0] exp_fetch;
    logic        outstanding;
    logic        killed;
    logic [63:0] out_addr;
    int          odelay;
    logic [31:0] m_instr;
    logic [63:0] m_pc;
    logic        m_vld;
    int          deliv;
    logic        acc;
    logic [63:0] pre_addr;
    logic [63:0] tgt;

    localparam int NCYC = 3000;

    initial begin
        // rst_n stall redir rpc rdy rv rdata | req addr instr pc_d valid
        tbl.push_back(mk(0,0,0,64'h0,1,0,32'h0,               0,64'h0,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h0,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'h00100093,        0,64'h4,32'h00100093,64'h0,1));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h4,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'h00208133,        0,64'h8,32'h00208133,64'h4,1));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h8,NOP,64'h4,0));
        tbl.push_back(mk(1,1,0,64'h0,1,1,32'h0000006F,        0,64'hC,NOP,64'h4,0));
        tbl.push_back(mk(1,1,0,64'h0,1,0,32'h0,               0,64'hC,NOP,64'h4,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               0,64'hC,32'h0000006F,64'h8,1));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'hC,NOP,64'h8,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'h00c00193,        0,64'h10,32'h00c00193,64'hC,1));
        tbl.push_back(mk(1,1,1,64'h100,1,0,32'h0,             0,64'h10,NOP,64'hC,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h100,NOP,64'hC,0));
        tbl.push_back(mk(1,0,1,64'h200,1,0,32'h0,             0,64'h104,NOP,64'hC,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'hdeadbeef,        0,64'h200,NOP,64'hC,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h200,NOP,64'hC,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'h00400213,        0,64'h204,32'h00400213,64'h200,1));
        tbl.push_back(mk(1,0,1,64'h106,1,0,32'h0,             0,64'h204,NOP,64'h200,0));
        tbl.push_back(mk(1,0,0,64'h0,0,0,32'h0,               1,64'h104,NOP,64'h200,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h104,NOP,64'h200,0));
        tbl.push_back(mk(1,0,1,64'hFFFF_FFFF_FFFF_FFFE,1,0,32'h0, 0,64'h108,NOP,64'h200,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'hcafef00d,        0,64'hFFFF_FFFF_FFFF_FFFC,NOP,64'h200,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'hFFFF_FFFF_FFFF_FFFC,NOP,64'h200,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'h00500293,        0,64'h0,32'h00500293,64'hFFFF_FFFF_FFFF_FFFC,1));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h0,NOP,64'hFFFF_FFFF_FFFF_FFFC,0));
        tbl.push_back(mk(1,1,0,64'h0,1,1,32'h11111111,        0,64'h4,NOP,64'hFFFF_FFFF_FFFF_FFFC,0));
        tbl.push_back(mk(0,1,0,64'h0,1,0,32'h0,               0,64'h4,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h0,NOP,64'h0,0));
        tbl.push_back(mk(0,0,0,64'h0,1,0,32'h0,               0,64'h4,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,0,1,32'hbad00bad,        1,64'h0,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,1,0,32'h0,               1,64'h0,NOP,64'h0,0));
        tbl.push_back(mk(1,0,0,64'h0,1,1,32'h00600313,        0,64'h4,32'h00600313,64'h0,1));

        reset = 1'b0; stall_D = 1'b0; redirect = 1'b0; redirect_PC = 64'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // A redirect must clear a parked response, not let it reach decode later.
        apply(mk(1,0,0,64'h0,1,0,32'h0,        1,64'h4,NOP,64'h0,0), "bufclr0");
        apply(mk(1,1,0,64'h0,1,1,32'h00700393, 0,64'h8,NOP,64'h0,0), "bufclr1");
        apply(mk(1,1,1,64'h300,1,0,32'h0,      0,64'h8,NOP,64'h0,0), "bufclr2");
        apply(mk(1,0,0,64'h0,0,0,32'h0,        1,64'h300,NOP,64'h0,0), "bufclr3");
        apply(mk(1,0,0,64'h0,1,0,32'h0,        1,64'h300,NOP,64'h0,0), "bufclr4");
        apply(mk(1,0,0,64'h0,1,1,32'h00800413, 0,64'h304,32'h00800413,64'h300,1), "bufclr5");

        // Randomized phase from a fresh reset.
        reset = 1'b0; stall_D = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        exp_fetch = 64'h0; outstanding = 1'b0; killed = 1'b0; out_addr = 64'h0; odelay = 0;
        m_instr = NOP; m_pc = 64'h0; m_vld = 1'b0; deliv = 0;

        for (int c = 0; c < NCYC; c++) begin
            stall_D     = (c < NCYC - 200) ? ($urandom_range(0, 99) < 30) : 1'b0;
            redirect    = (c < NCYC - 200) ? ($urandom_range(0, 99) < 7) : 1'b0;
            tgt         = {$urandom(), $urandom()};
            redirect_PC = tgt;
            imem_ready  = ($urandom_range(0, 99) < 70);
            if (outstanding && odelay == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(out_addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
            end
            #1;
            if (redirect || outstanding || q.size() != 0) begin
                chk($sformatf("rnd%0d req_idle", c), {63'h0, imem_req}, 64'h0);
            end
            acc      = imem_req && imem_ready;
            pre_addr = imem_addr;
            if (acc) chk($sformatf("rnd%0d fetch_addr", c), pre_addr, exp_fetch);
            @(posedge clk);
            #1;

            if (redirect) begin
                q.delete();
                if (imem_rvalid) outstanding = 1'b0;
                else if (outstanding) killed = 1'b1;
                exp_fetch = {tgt[63:2], 2'b00};
                m_vld = 1'b0;
                m_instr = NOP;
            end else begin
                if (imem_rvalid) begin
                    if (!killed) begin
                        e.instr = imem_rdata;
                        e.pc    = out_addr;
                        q.push_back(e);
                    end
                    outstanding = 1'b0;
                    killed = 1'b0;
                end else if (outstanding && odelay > 0) begin
                    odelay--;
                end
                if (!stall_D) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        m_instr = e.instr;
                        m_pc = e.pc;
                        m_vld = 1'b1;
                        deliv++;
                    end else begin
                        m_instr = NOP;
                        m_vld = 1'b0;
                    end
                end
            end
            if (acc) begin
                outstanding = 1'b1;
                killed = 1'b0;
                out_addr = pre_addr;
                odelay = $urandom_range(0, 2);
                exp_fetch = pre_addr + 64'd4;
            end

            chk($sformatf("rnd%0d instr", c), {32'h0, instruction_D}, {32'h0, m_instr});
            chk($sformatf("rnd%0d pc_d", c), PC_D, m_pc);
            chk($sformatf("rnd%0d valid", c), {63'h0, valid_D}, {63'h0, m_vld});
        end

        total++;
        if (deliv < 100) begin
            bad++;
            $display("FAIL rnd deliveries: got %0d want at least 100", deliv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
